// File: rtl/dz_pkg.sv
// Shared types and constants for the dz_count dot-matrix display: colours, scan states
// and the 8x8 digit font.
package dz_pkg;

  typedef enum logic [1:0] {
    COL_OFF = 2'd0,
    COL_R   = 2'd1,
    COL_G   = 2'd2,
    COL_Y   = 2'd3
  } color_e;

  typedef enum logic {
    StBlank,
    StDrive
  } scan_st_e;

  typedef struct packed {
    logic [3:0] digit;
    color_e     color;
    logic       blink;
  } disp_t;

  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned NUM_COLS = 8;

  // Row 0 is left blank so glyphs sit one row down from the top edge.
  localparam logic [NUM_COLS-1:0] FONT [10][NUM_ROWS] = '{
    '{8'h00, 8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C},
    '{8'h00, 8'h18, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h7E},
    '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E},
    '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C},
    '{8'h00, 8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h0C},
    '{8'h00, 8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C},
    '{8'h00, 8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C},
    '{8'h00, 8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30},
    '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C},
    '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38}
  };

endpackage

// File: rtl/dz_glyph_rom.sv
// Combinational font lookup: one 8-bit glyph row for a digit; codes above 9 render blank.
module dz_glyph_rom
  import dz_pkg::*;
(
  input  logic [3:0]          digit,
  input  logic [2:0]          row_idx,
  output logic [NUM_COLS-1:0] pattern
);

  always_comb begin
    pattern = '0;
    if (digit <= 4'd9) begin
      pattern = FONT[digit][row_idx];
    end
  end

endmodule

// File: rtl/dz_scan_ctrl.sv
// Row-scan controller for the 8x8 bicolour matrix: scan counters, frame-synchronous
// digit update, blanking/blink gating and registered row/column outputs.
module dz_scan_ctrl
  import dz_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK        = 2,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          digit,
  input  logic [1:0]          color,
  input  logic                blink,
  input  logic                load,
  output logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] colr,
  output logic [NUM_COLS-1:0] colg,
  output logic                frame_done,
  output logic                busy
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DivW-1:0]     div_q, div_nxt;
  logic [2:0]          row_q;
  logic [FrmW-1:0]     frm_q;
  logic                phase_q;
  scan_st_e            st_q;
  disp_t               act_q, pend_q;
  logic                pend_valid_q;
  logic                div_wrap, frame_end, frm_wrap, show;
  logic [NUM_COLS-1:0] glyph;

  dz_glyph_rom u_glyph_rom (
    .digit   (act_q.digit),
    .row_idx (row_q),
    .pattern (glyph)
  );

  always_comb begin
    div_wrap  = (div_q == DivW'(SCAN_DIV - 1));
    frame_end = div_wrap && (row_q == 3'd7);
    frm_wrap  = (frm_q == FrmW'(BLINK_FRAMES - 1));
    div_nxt   = div_wrap ? '0 : div_q + DivW'(1);
    show      = (st_q == StDrive) && (act_q.color != COL_OFF) && (act_q.digit <= 4'd9) &&
                !(act_q.blink && phase_q);
  end

  assign busy = pend_valid_q;

  // Outputs are computed from the pre-edge counter state, so they lag the counters by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q        <= '0;
      row_q        <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b0;
      st_q         <= (BLANK > 0) ? StBlank : StDrive;
      act_q        <= '{digit: 4'd0, color: COL_OFF, blink: 1'b0};
      pend_q       <= '{digit: 4'd0, color: COL_OFF, blink: 1'b0};
      pend_valid_q <= 1'b0;
      row          <= '1;
      colr         <= '0;
      colg         <= '0;
      frame_done   <= 1'b0;
    end else begin
      div_q <= div_nxt;
      st_q  <= (32'(div_nxt) < BLANK) ? StBlank : StDrive;
      if (div_wrap) begin
        row_q <= row_q + 3'd1;
      end
      if (frame_end) begin
        frm_q <= frm_wrap ? '0 : frm_q + FrmW'(1);
        if (frm_wrap) begin
          phase_q <= ~phase_q;
        end
        if (pend_valid_q) begin
          act_q <= pend_q;
        end
      end
      // A load on the boundary cycle lands in pending and waits for the next boundary.
      if (load) begin
        pend_q <= '{digit: digit, color: color_e'(color), blink: blink};
      end
      pend_valid_q <= load || (pend_valid_q && !frame_end);

      row        <= ~(8'h01 << row_q);
      colr       <= (show && act_q.color[0]) ? glyph : '0;
      colg       <= (show && act_q.color[1]) ? glyph : '0;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// Scoreboard bench for dz_scan_ctrl: stimulus pushes expected outputs per cycle, a negedge
// monitor pops and compares them against the DUT.
module tb_dz_scan_ctrl;

  localparam int unsigned SD = 4;
  localparam int unsigned BL = 1;
  localparam int unsigned BF = 2;
  localparam int unsigned FR = 8 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit = '0;
  logic [1:0] color = '0;
  logic       blink = 1'b0;
  logic       load = 1'b0;
  logic [7:0] row, colr, colg;
  logic       frame_done, busy;

  dz_scan_ctrl #(
    .SCAN_DIV     (SD),
    .BLANK        (BL),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit      (digit),
    .color      (color),
    .blink      (blink),
    .load       (load),
    .row        (row),
    .colr       (colr),
    .colg       (colg),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic       fd;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  logic [7:0] font [10][8] = '{
    '{8'h00, 8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C},
    '{8'h00, 8'h18, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h7E},
    '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E},
    '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C},
    '{8'h00, 8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h0C},
    '{8'h00, 8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C},
    '{8'h00, 8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C},
    '{8'h00, 8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30},
    '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C},
    '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38}
  };

  // Reference state: cycles since reset release, displayed and pending content.
  int         cnt;
  logic [3:0] a_d, p_d;
  logic [1:0] a_c, p_c;
  logic       a_b, p_b, p_v;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("row", row, e.row);
      chk("colr", colr, e.colr);
      chk("colg", colg, e.colg);
      chk("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
      chk("busy", {7'd0, busy}, {7'd0, e.busy});
    end
  end

  task automatic model_clear();
    cnt = 0;
    a_d = '0; a_c = '0; a_b = 1'b0;
    p_d = '0; p_c = '0; p_b = 1'b0; p_v = 1'b0;
  endtask

  task automatic tick();
    exp_t       e;
    int         pos, r, p, phase;
    logic [7:0] g;
    logic       vis;
    @(posedge clk);
    #1;
    pos   = cnt % FR;
    r     = pos / SD;
    p     = pos % SD;
    phase = ((cnt / FR) / BF) % 2;
    g     = (a_d <= 4'd9) ? font[a_d][r] : 8'h00;
    vis   = (p >= BL) && (a_c != 2'd0) && (a_d <= 4'd9) && !(a_b && phase == 1);
    e.row  = ~(8'h01 << r);
    e.colr = (vis && a_c[0]) ? g : 8'h00;
    e.colg = (vis && a_c[1]) ? g : 8'h00;
    e.fd   = (pos == FR - 1);
    if (pos == FR - 1 && p_v) begin
      a_d = p_d; a_c = p_c; a_b = p_b; p_v = 1'b0;
    end
    if (load) begin
      p_d = digit; p_c = color; p_b = blink; p_v = 1'b1;
    end
    e.busy = p_v;
    q.push_back(e);
    cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [3:0] d, input logic [1:0] c, input logic b);
    digit = d; color = c; blink = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic to_boundary();
    while (cnt % FR != FR - 1) tick();
  endtask

  // Reset asserted between edges; the first check lands before any further clock edge.
  task automatic do_reset();
    exp_t r;
    r = '{row: 8'hFF, colr: 8'h00, colg: 8'h00, fd: 1'b0, busy: 1'b0};
    @(posedge clk);
    #2 rst = 1'b0;
    load = 1'b0;
    #1 q.push_back(r);
    @(posedge clk);
    #1 q.push_back(r);
    model_clear();
    #1 rst = 1'b1;
  endtask

  initial begin
    model_clear();
    do_reset();
    ticks(FR);
    ticks(9);
    do_load(4'd1, 2'd2, 1'b0);
    ticks(2 * FR);
    do_load(4'd1, 2'd3, 1'b0);
    ticks(2 * FR);
    do_load(4'd1, 2'd1, 1'b0);
    ticks(2 * FR);
    ticks(5);
    do_load(4'd4, 2'd3, 1'b0);
    ticks(7);
    do_load(4'd7, 2'd3, 1'b0);
    to_boundary();
    do_load(4'd2, 2'd2, 1'b0);
    ticks(2 * FR);
    do_load(4'd8, 2'd3, 1'b1);
    ticks(8 * FR);
    do_load(4'd12, 2'd1, 1'b0);
    ticks(2 * FR);
    do_load(4'd5, 2'd1, 1'b0);
    ticks(2 * FR);
    ticks(6);
    do_load(4'd3, 2'd2, 1'b0);
    ticks(3);
    do_reset();
    ticks(2 * FR);
    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
